// File: rtl/mem_write_arbiter.sv
// Three-way write-port arbiter for the 16x8 clock/chronometer register memory.
// Optional RTC_PRIORITY_EN: requester 0 gets fixed top priority in IDLE.
module mem_write_arbiter #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] dat0,
  input  logic [DATA_W-1:0] dat1,
  input  logic [DATA_W-1:0] dat2,
  output logic [2:0]        gnt,
  output logic [ADDR_W-1:0] ADD1,
  output logic [DATA_W-1:0] DAT1,
  output logic              w1,
  output logic              busy
);

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] owner;
  logic [3:0] bcnt;

  logic [1:0] winner;
  logic       found;
  logic       owner_go;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Pick the IDLE winner.
`ifdef RTC_PRIORITY_EN
  logic [1:0] first_rr;
  logic [1:0] second_rr;
  always_comb begin
    first_rr  = (ptr == 2'd2) ? 2'd2 : 2'd1;
    second_rr = (ptr == 2'd2) ? 2'd1 : 2'd2;
    found     = 1'b0;
    winner    = 2'd0;
    if (req[0]) begin
      found  = 1'b1;
      winner = 2'd0;
    end else if (req[first_rr]) begin
      found  = 1'b1;
      winner = first_rr;
    end else if (req[second_rr]) begin
      found  = 1'b1;
      winner = second_rr;
    end
  end
`else
  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;
  always_comb begin
    c0     = ptr;
    c1     = inc3(ptr);
    c2     = inc3(c1);
    found  = 1'b0;
    winner = c0;
    if (req[c0]) begin
      found  = 1'b1;
      winner = c0;
    end else if (req[c1]) begin
      found  = 1'b1;
      winner = c1;
    end else if (req[c2]) begin
      found  = 1'b1;
      winner = c2;
    end
  end
`endif

  assign owner_go = req[owner] && lock[owner] && (bcnt < MAXB);

  // Combinational grant; suppressed entirely while reset is asserted.
  always_comb begin
    gnt = 3'b000;
    if (!reset) begin
      case (state)
        IDLE:    if (found)    gnt[winner] = 1'b1;
        LOCKED:  if (owner_go) gnt[owner]  = 1'b1;
        default: gnt = 3'b000;
      endcase
    end
  end

  always_comb begin
    ADD1 = '0;
    DAT1 = '0;
    if (gnt[0]) begin
      ADD1 = addr0;
      DAT1 = dat0;
    end else if (gnt[1]) begin
      ADD1 = addr1;
      DAT1 = dat1;
    end else if (gnt[2]) begin
      ADD1 = addr2;
      DAT1 = dat2;
    end
  end

  assign w1   = |gnt;
  assign busy = !reset && (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      owner <= 2'd0;
      bcnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
`ifdef RTC_PRIORITY_EN
            // Requester 0 does not disturb the 1/2 rotation.
            if (winner != 2'd0) ptr <= inc3(winner);
`else
            ptr <= inc3(winner);
`endif
            if (lock[winner]) begin
              state <= LOCKED;
              owner <= winner;
              bcnt  <= 4'd1;
            end
          end
        end
        LOCKED: begin
          if (owner_go) begin
            bcnt <= bcnt + 4'd1;
          end else begin
            state <= IDLE;
            bcnt  <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
